// File: rtl/ipm2l_hsstlp_rst_pkg.sv
// Shared definitions for the HSSTLP lane reset sequencer: FSM state
// encoding, lock debounce length and the state-to-output decode.
package ipm2l_hsstlp_rst_pkg;

   // Bring-up sequencer states, 4-bit encoding
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      PLL_RST  = 4'd1,
      PLL_WAIT = 4'd2,
      TX_RST   = 4'd3,
      CDR_WAIT = 4'd4,
      RX_RST   = 4'd5,
      DONE     = 4'd6,
      RETRY    = 4'd7,
      FAIL     = 4'd8
   } lane_state_e;

   // Consecutive synced-high cycles before a lock is trusted (debounce build only)
   localparam int LOCK_DB_CYCLES = 64;

   // Registered control outputs, all derived from a single state value
   typedef struct packed {
      logic pll_rst;
      logic tx_rst;
      logic rx_rst;
      logic lane_ready;
      logic lane_fail;
   } lane_out_t;

   // Output decode; unknown encodings fall back to the all-reset safe state
   function automatic lane_out_t decode_outputs(input lane_state_e st);
      lane_out_t o;
      o.pll_rst    = 1'b1;
      o.tx_rst     = 1'b1;
      o.rx_rst     = 1'b1;
      o.lane_ready = 1'b0;
      o.lane_fail  = 1'b0;
      case (st)
         IDLE, PLL_RST, RETRY: begin
            o.pll_rst = 1'b1;
            o.tx_rst  = 1'b1;
            o.rx_rst  = 1'b1;
         end
         PLL_WAIT, TX_RST: begin
            o.pll_rst = 1'b0;
            o.tx_rst  = 1'b1;
            o.rx_rst  = 1'b1;
         end
         CDR_WAIT, RX_RST: begin
            o.pll_rst = 1'b0;
            o.tx_rst  = 1'b0;
            o.rx_rst  = 1'b1;
         end
         DONE: begin
            o.pll_rst    = 1'b0;
            o.tx_rst     = 1'b0;
            o.rx_rst     = 1'b0;
            o.lane_ready = 1'b1;
         end
         FAIL: begin
            o.lane_fail = 1'b1;
         end
         default: begin
            o.pll_rst    = 1'b1;
            o.tx_rst     = 1'b1;
            o.rx_rst     = 1'b1;
            o.lane_ready = 1'b0;
            o.lane_fail  = 1'b0;
         end
      endcase
      return o;
   endfunction

endpackage

// File: rtl/ipm2l_hsstlp_lock_sync.sv
// Two-flop synchroniser for an asynchronous HSST lock indication.
// Optional feature macro: LOCK_DEBOUNCE_EN -- when defined, the synced lock
// is only reported after LOCK_DB_CYCLES consecutive high cycles; a single low
// cycle restarts the count and loss is reported without extra delay.
module ipm2l_hsstlp_lock_sync
   import ipm2l_hsstlp_rst_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic lock_async,
   output logic lock
);

   logic meta_r;
   logic sync_r;

   // Two-stage metastability filter on the asynchronous lock
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= lock_async;
         sync_r <= meta_r;
      end
   end

`ifdef LOCK_DEBOUNCE_EN
   localparam int              DB_W    = $clog2(LOCK_DB_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_FULL = DB_W'(LOCK_DB_CYCLES);

   logic [DB_W-1:0] db_cnt_r;

   // Count consecutive synced-high cycles, saturating once lock is trusted
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt_r <= '0;
      end else if (!sync_r) begin
         db_cnt_r <= '0;
      end else if (db_cnt_r != DB_FULL) begin
         db_cnt_r <= db_cnt_r + DB_W'(1);
      end else begin
         db_cnt_r <= db_cnt_r;
      end
   end

   // Gating with sync_r keeps loss-of-lock as fast as the plain synchroniser
   assign lock = sync_r & (db_cnt_r == DB_FULL);
`else
   assign lock = sync_r;
`endif

endmodule

// File: rtl/ipm2l_hsstlp_lane_rst_seq.sv
// HSSTLP lane bring-up reset sequencer. Releases PLL, TX and RX resets in
// order, waiting for synchronised PLL and CDR lock, retrying on timeout and
// parking in FAIL once the retry budget is spent.
// Optional feature macro: LOCK_DEBOUNCE_EN (handled inside the lock syncs).
module ipm2l_hsstlp_lane_rst_seq
   import ipm2l_hsstlp_rst_pkg::*;
#(
   parameter int RST_HOLD    = 16,
   parameter int PLL_TIMEOUT = 4096,
   parameter int CDR_TIMEOUT = 8192,
   parameter int RETRY_MAX   = 3,
   parameter int CNT_W       = 14
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pll_lock_async,
   input  logic       cdr_lock_async,
   output logic       pll_rst,
   output logic       tx_rst,
   output logic       rx_rst,
   output logic       lane_ready,
   output logic       lane_fail,
   output logic [1:0] retry_cnt
);

   // Terminal timer values; the timer restarts at zero on every state entry
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CDR_LAST  = CNT_W'(CDR_TIMEOUT - 1);
   localparam logic [1:0]       RETRY_LIM = 2'(RETRY_MAX);

   lane_state_e      state_r;
   lane_state_e      state_nxt_s;
   logic [CNT_W-1:0] timer_r;
   logic [1:0]       retry_cnt_r;
   logic             start_q_r;
   logic             pll_lk_s;
   logic             cdr_lk_s;
   logic             hold_done_s;
   logic             timer_run_s;
   logic             start_rise_s;
   lane_out_t        out_nxt_s;

   ipm2l_hsstlp_lock_sync u_pll_sync (
      .clk        (clk),
      .rst        (rst),
      .lock_async (pll_lock_async),
      .lock       (pll_lk_s)
   );

   ipm2l_hsstlp_lock_sync u_cdr_sync (
      .clk        (clk),
      .rst        (rst),
      .lock_async (cdr_lock_async),
      .lock       (cdr_lk_s)
   );

   assign hold_done_s  = (timer_r == HOLD_LAST);
   assign start_rise_s = start & ~start_q_r;
   assign out_nxt_s    = decode_outputs(state_nxt_s);
   assign retry_cnt    = retry_cnt_r;

   // Timer only advances in states that have a hold or timeout to measure
   always_comb begin
      case (state_r)
         PLL_RST, PLL_WAIT, TX_RST, CDR_WAIT, RX_RST: timer_run_s = 1'b1;
         default:                                    timer_run_s = 1'b0;
      endcase
   end

   // Next-state selection; PLL loss beats everything else, lock beats timeout
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = PLL_RST;
            else       state_nxt_s = IDLE;
         end
         PLL_RST: begin
            if (hold_done_s) state_nxt_s = PLL_WAIT;
            else             state_nxt_s = PLL_RST;
         end
         PLL_WAIT: begin
            if (pll_lk_s)                  state_nxt_s = TX_RST;
            else if (timer_r == PLL_LAST)  state_nxt_s = RETRY;
            else                           state_nxt_s = PLL_WAIT;
         end
         TX_RST: begin
            if (!pll_lk_s)        state_nxt_s = PLL_RST;
            else if (hold_done_s) state_nxt_s = CDR_WAIT;
            else                  state_nxt_s = TX_RST;
         end
         CDR_WAIT: begin
            if (!pll_lk_s)                 state_nxt_s = PLL_RST;
            else if (cdr_lk_s)             state_nxt_s = RX_RST;
            else if (timer_r == CDR_LAST)  state_nxt_s = RETRY;
            else                           state_nxt_s = CDR_WAIT;
         end
         RX_RST: begin
            if (!pll_lk_s)        state_nxt_s = PLL_RST;
            else if (hold_done_s) state_nxt_s = DONE;
            else                  state_nxt_s = RX_RST;
         end
         DONE: begin
            if (!pll_lk_s)      state_nxt_s = PLL_RST;
            else if (!cdr_lk_s) state_nxt_s = CDR_WAIT;
            else                state_nxt_s = DONE;
         end
         RETRY: begin
            if (retry_cnt_r >= RETRY_LIM) state_nxt_s = FAIL;
            else                          state_nxt_s = PLL_RST;
         end
         FAIL: begin
            if (start_rise_s) state_nxt_s = PLL_RST;
            else              state_nxt_s = FAIL;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state, timer, retry budget and outputs registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         timer_r     <= '0;
         retry_cnt_r <= 2'd0;
         start_q_r   <= 1'b0;
         pll_rst     <= 1'b1;
         tx_rst      <= 1'b1;
         rx_rst      <= 1'b1;
         lane_ready  <= 1'b0;
         lane_fail   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         start_q_r <= start;

         if (state_nxt_s != state_r) begin
            timer_r <= '0;
         end else if (timer_run_s) begin
            timer_r <= timer_r + CNT_W'(1);
         end else begin
            timer_r <= '0;
         end

         if ((state_r == RETRY) && (retry_cnt_r < RETRY_LIM)) begin
            retry_cnt_r <= retry_cnt_r + 2'd1;
         end else if ((state_r == FAIL) && start_rise_s) begin
            retry_cnt_r <= 2'd0;
         end else begin
            retry_cnt_r <= retry_cnt_r;
         end

         pll_rst    <= out_nxt_s.pll_rst;
         tx_rst     <= out_nxt_s.tx_rst;
         rx_rst     <= out_nxt_s.rx_rst;
         lane_ready <= out_nxt_s.lane_ready;
         lane_fail  <= out_nxt_s.lane_fail;
      end
   end

endmodule

// File: tb/tb_ipm2l_hsstlp_lane_rst_seq.sv
// Directed bench for the lane reset sequencer (default build, no debounce).
// A vector table walks the bring-up, CDR drop, PLL+CDR drop, retry, reset
// and FAIL/restart paths; hand sequences then measure exact latencies.
module tb_ipm2l_hsstlp_lane_rst_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic       pll_lock_async;
   logic       cdr_lock_async;
   logic       pll_rst;
   logic       tx_rst;
   logic       rx_rst;
   logic       lane_ready;
   logic       lane_fail;
   logic [1:0] retry_cnt;

   int checks   = 0;
   int failures = 0;

   // expected = {pll_rst, tx_rst, rx_rst, lane_ready, lane_fail, retry_cnt[1:0]}
   typedef struct {
      logic       rst;
      logic       start;
      logic       pll;
      logic       cdr;
      int         n;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];

   ipm2l_hsstlp_lane_rst_seq #(
      .RST_HOLD    (16),
      .PLL_TIMEOUT (64),
      .CDR_TIMEOUT (128),
      .RETRY_MAX   (3),
      .CNT_W       (14)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .pll_lock_async (pll_lock_async),
      .cdr_lock_async (cdr_lock_async),
      .pll_rst        (pll_rst),
      .tx_rst         (tx_rst),
      .rx_rst         (rx_rst),
      .lane_ready     (lane_ready),
      .lane_fail      (lane_fail),
      .retry_cnt      (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic s, input logic p, input logic c,
                      input int n, input logic [6:0] e);
      vec_t v;
      v.rst = r; v.start = s; v.pll = p; v.cdr = c; v.n = n; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      logic [6:0] act;
      int         cnt;

      rst = 1'b1; start = 1'b0; pll_lock_async = 1'b0; cdr_lock_async = 1'b0;

      // Cycle counts below are edges after the reset vector (t).
      add(1'b1, 1'b0, 1'b0, 1'b0,  2, 7'b111_00_00); // reset values
      // bring-up
      add(1'b0, 1'b1, 1'b0, 1'b0,  1, 7'b111_00_00); // t1  PLL_RST
      add(1'b0, 1'b1, 1'b0, 1'b0, 15, 7'b111_00_00); // t16 last PLL_RST cycle
      add(1'b0, 1'b1, 1'b0, 1'b0,  1, 7'b011_00_00); // t17 PLL_WAIT
      add(1'b0, 1'b1, 1'b0, 1'b0, 12, 7'b011_00_00); // t29
      add(1'b0, 1'b1, 1'b1, 1'b0, 18, 7'b011_00_00); // t47 TX_RST since t32
      add(1'b0, 1'b1, 1'b1, 1'b0,  1, 7'b001_00_00); // t48 CDR_WAIT
      add(1'b0, 1'b1, 1'b1, 1'b0, 20, 7'b001_00_00); // t68
      add(1'b0, 1'b1, 1'b1, 1'b1, 18, 7'b001_00_00); // t86 RX_RST since t71
      add(1'b0, 1'b1, 1'b1, 1'b1,  1, 7'b000_10_00); // t87 DONE
      // one-cycle CDR drop in DONE
      add(1'b0, 1'b1, 1'b1, 1'b1,  2, 7'b000_10_00); // t89
      add(1'b0, 1'b1, 1'b1, 1'b0,  1, 7'b000_10_00); // t90
      add(1'b0, 1'b1, 1'b1, 1'b1,  1, 7'b000_10_00); // t91
      add(1'b0, 1'b1, 1'b1, 1'b1,  1, 7'b001_00_00); // t92 CDR_WAIT
      add(1'b0, 1'b1, 1'b1, 1'b1, 16, 7'b001_00_00); // t108 RX_RST since t93
      add(1'b0, 1'b1, 1'b1, 1'b1,  1, 7'b000_10_00); // t109 DONE again
      // PLL+CDR drop together, start released; one timeout then relock
      add(1'b0, 1'b0, 1'b0, 1'b0,  2, 7'b000_10_00); // t111
      add(1'b0, 1'b0, 1'b0, 1'b0,  1, 7'b111_00_00); // t112 PLL_RST
      add(1'b0, 1'b0, 1'b0, 1'b0, 16, 7'b011_00_00); // t128 PLL_WAIT
      add(1'b0, 1'b0, 1'b0, 1'b0, 63, 7'b011_00_00); // t191 timer==63 next
      add(1'b0, 1'b0, 1'b0, 1'b0,  1, 7'b111_00_00); // t192 RETRY
      add(1'b0, 1'b0, 1'b0, 1'b0,  1, 7'b111_00_01); // t193 PLL_RST, retry 1
      add(1'b0, 1'b0, 1'b1, 1'b1, 16, 7'b011_00_01); // t209 PLL_WAIT
      add(1'b0, 1'b0, 1'b1, 1'b1, 17, 7'b001_00_01); // t226 CDR_WAIT
      add(1'b0, 1'b0, 1'b1, 1'b1, 16, 7'b001_00_01); // t242 RX_RST
      add(1'b0, 1'b0, 1'b1, 1'b1,  1, 7'b000_10_01); // t243 DONE keeps retry
      add(1'b0, 1'b0, 1'b0, 1'b0,  2, 7'b000_10_01); // t245
      add(1'b0, 1'b0, 1'b0, 1'b0,  1, 7'b111_00_01); // t246 PLL wins, retry kept
      // reset in CDR_WAIT
      add(1'b0, 1'b0, 1'b1, 1'b0, 33, 7'b001_00_01); // t279 CDR_WAIT
      add(1'b0, 1'b0, 1'b1, 1'b0,  5, 7'b001_00_01); // t284
      add(1'b1, 1'b0, 1'b1, 1'b0,  1, 7'b111_00_00); // t285 reset values
      // PLL never locks: four attempts then FAIL
      add(1'b0, 1'b1, 1'b0, 1'b0,  1, 7'b111_00_00); // t286 PLL_RST
      add(1'b0, 1'b1, 1'b0, 1'b0, 79, 7'b011_00_00); // t365
      add(1'b0, 1'b1, 1'b0, 1'b0,  2, 7'b111_00_01); // t367
      add(1'b0, 1'b1, 1'b0, 1'b0, 79, 7'b011_00_01); // t446
      add(1'b0, 1'b1, 1'b0, 1'b0,  2, 7'b111_00_10); // t448
      add(1'b0, 1'b1, 1'b0, 1'b0, 79, 7'b011_00_10); // t527
      add(1'b0, 1'b1, 1'b0, 1'b0,  2, 7'b111_00_11); // t529
      add(1'b0, 1'b1, 1'b0, 1'b0, 79, 7'b011_00_11); // t608
      add(1'b0, 1'b1, 1'b0, 1'b0,  1, 7'b111_00_11); // t609 RETRY
      add(1'b0, 1'b1, 1'b0, 1'b0,  1, 7'b111_01_11); // t610 FAIL
      add(1'b0, 1'b1, 1'b0, 1'b0,  5, 7'b111_01_11); // held start: no restart
      add(1'b0, 1'b0, 1'b0, 1'b0,  2, 7'b111_01_11);
      add(1'b0, 1'b1, 1'b0, 1'b0,  1, 7'b111_00_00); // rising start: PLL_RST
      add(1'b0, 1'b1, 1'b0, 1'b0, 16, 7'b011_00_00); // PLL_WAIT entry T
      // lock seen on the timeout cycle wins
      add(1'b0, 1'b1, 1'b0, 1'b0, 61, 7'b011_00_00); // T+61
      add(1'b0, 1'b1, 1'b1, 1'b0,  3, 7'b011_00_00); // T+64 TX_RST, not RETRY
      add(1'b0, 1'b1, 1'b1, 1'b0,  1, 7'b011_00_00); // T+65
      // PLL loss in TX_RST restarts without consuming a retry
      add(1'b0, 1'b1, 1'b0, 1'b0,  2, 7'b011_00_00); // T+67
      add(1'b0, 1'b1, 1'b0, 1'b0,  1, 7'b111_00_00); // T+68 PLL_RST

      foreach (vecs[i]) begin
         rst            = vecs[i].rst;
         start          = vecs[i].start;
         pll_lock_async = vecs[i].pll;
         cdr_lock_async = vecs[i].cdr;
         repeat (vecs[i].n) tick();
         act = {pll_rst, tx_rst, rx_rst, lane_ready, lane_fail, retry_cnt};
         checks++;
         if (act !== vecs[i].exp) begin
            failures++;
            $display("FAIL vec%0d: got %b expected %b", i, act, vecs[i].exp);
         end
      end

      // Hand sequence: exact bring-up latencies from a fresh reset
      rst = 1'b1; start = 1'b0; pll_lock_async = 1'b0; cdr_lock_async = 1'b0;
      tick(); tick();
      rst = 1'b0; start = 1'b1;
      cnt = 0;
      while (pll_rst === 1'b1 && cnt < 200) begin tick(); cnt++; end
      check_int("pll_rst_fall_cycle", cnt, 17);
      while (cnt < 29) begin tick(); cnt++; end
      pll_lock_async = 1'b1;
      cnt = 0;
      while (tx_rst === 1'b1 && cnt < 200) begin tick(); cnt++; end
      // 2 sync edges + 1 decision edge + 16 TX_RST cycles
      check_int("tx_rst_fall_after_pll_lock", cnt, 19);
      repeat (20) tick();
      cdr_lock_async = 1'b1;
      cnt = 0;
      while (lane_ready !== 1'b1 && cnt < 200) begin tick(); cnt++; end
      // first sampling edge, then 2 sync edges + 16 RX_RST cycles
      check_int("lane_ready_after_cdr_lock", cnt, 19);
      check_int("resets_in_done", int'({pll_rst, tx_rst, rx_rst}), 0);
      check_int("retry_in_done", int'(retry_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
